// File: rtl/pipe_mon_pkg.sv
// rtl/pipe_mon_pkg.sv - shared types and constants for the retire-stream monitor
//
// Contents:
//   mon_state_e              monitor FSM state, also reported in the status word
//   SEL_*                    readout select codes for i_rd_sel
//   ST_*                     bit positions inside the status readout word
package pipe_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        HANG = 2'd3
    } mon_state_e;

    localparam logic [2:0] SEL_CYC    = 3'd0;
    localparam logic [2:0] SEL_RET    = 3'd1;
    localparam logic [2:0] SEL_CTRL   = 3'd2;
    localparam logic [2:0] SEL_MIS    = 3'd3;
    localparam logic [2:0] SEL_GAP    = 3'd4;
    localparam logic [2:0] SEL_PC     = 3'd5;
    localparam logic [2:0] SEL_STATUS = 3'd6;
    localparam logic [2:0] SEL_ZERO   = 3'd7;

    // Status word: {proto_err, hang, done, state[1:0]}
    localparam int ST_STATE_LSB = 0;
    localparam int ST_DONE_BIT  = 2;
    localparam int ST_HANG_BIT  = 3;
    localparam int ST_PERR_BIT  = 4;
    localparam int ST_W         = 5;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_inc            count one event this cycle
//   i_clr            synchronous clear, wins over i_inc
//   o_cnt            current count, holds at all-ones once reached
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_retire_monitor.sv
// rtl/pipe_retire_monitor.sv - retire-stream statistics, completion and hang monitor
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_insn_vld            an instruction retires this cycle
//   i_ctrl, i_mispred     retiring insn is control flow / was mispredicted
//   i_pc_debug            PC of the retiring instruction
//   i_clear               synchronous clear of all counters, flags and FSM
//   i_rd_sel              readout select (see SEL_* in pipe_mon_pkg)
//   o_rd_data             registered readout, one cycle behind i_rd_sel
//   o_done, o_hang        sticky completion / watchdog flags
//   o_proto_err           sticky: mispredict flagged on a non-control retire
module pipe_retire_monitor
    import pipe_mon_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 1024,
    parameter int DONE_REPEAT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_insn_vld,
    input  logic             i_ctrl,
    input  logic             i_mispred,
    input  logic [31:0]      i_pc_debug,
    input  logic             i_clear,
    input  logic [2:0]       i_rd_sel,
    output logic [CNT_W-1:0] o_rd_data,
    output logic             o_done,
    output logic             o_hang,
    output logic             o_proto_err
);

    // The gap counter never exceeds STALL_LIMIT because RUN is left when it
    // gets there, so it only needs enough bits for that value.
    localparam int GAP_W = $clog2(STALL_LIMIT + 1);
    localparam int REP_W = $clog2(DONE_REPEAT + 1);
    localparam int PC_N  = (CNT_W < 32)    ? CNT_W : 32;
    localparam int ST_N  = (CNT_W < ST_W)  ? CNT_W : ST_W;
    localparam int GAP_N = (CNT_W < GAP_W) ? CNT_W : GAP_W;

    mon_state_e state_q, state_d;

    logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
    logic [GAP_W-1:0] max_gap_q, max_gap_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic             proto_err_q, proto_err_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic [CNT_W-1:0] cyc_cnt, ret_cnt, ctrl_cnt, mis_cnt;
    logic [CNT_W-1:0] rd_mux, pc_ext, st_ext, gap_ext;
    logic [ST_W-1:0]  st_vec;
    logic             gap_ovf;

    logic cnt_active;
    logic retire;
    logic done_hit;
    logic stall_hit;
    logic hang_enter;

    // The first retire is seen while still in IDLE; it already counts so that
    // cyc_cnt and ret_cnt both start from that cycle.
    assign cnt_active = (state_q == RUN) || ((state_q == IDLE) && i_insn_vld);
    assign retire     = cnt_active && i_insn_vld;

    assign gap_inc    = gap_q + GAP_W'(1);
    assign done_hit   = (state_q == RUN) && (rep_q == REP_W'(DONE_REPEAT));
    assign stall_hit  = (state_q == RUN) && !i_insn_vld && (gap_inc == GAP_W'(STALL_LIMIT));
    // Completion takes precedence over the watchdog in the same cycle.
    assign hang_enter = stall_hit && !done_hit;

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (cnt_active),
        .i_clr   (i_clear),
        .o_cnt   (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (retire),
        .i_clr   (i_clear),
        .o_cnt   (ret_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ctrl_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (retire && i_ctrl),
        .i_clr   (i_clear),
        .o_cnt   (ctrl_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (retire && i_ctrl && i_mispred),
        .i_clr   (i_clear),
        .o_cnt   (mis_cnt)
    );

    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_insn_vld) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (done_hit) begin
                        state_d = DONE;
                    end else if (stall_hit) begin
                        state_d = HANG;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        gap_d       = gap_q;
        max_gap_d   = max_gap_q;
        rep_d       = rep_q;
        last_pc_d   = last_pc_q;
        proto_err_d = proto_err_q;
        rd_data_d   = rd_mux;
        if (i_clear) begin
            gap_d       = '0;
            max_gap_d   = '0;
            rep_d       = '0;
            last_pc_d   = '0;
            proto_err_d = 1'b0;
            rd_data_d   = '0;
        end else begin
            if (i_insn_vld && i_mispred && !i_ctrl) begin
                proto_err_d = 1'b1;
            end
            if (retire) begin
                if (gap_q > max_gap_q) begin
                    max_gap_d = gap_q;
                end
                gap_d     = '0;
                last_pc_d = i_pc_debug;
                if (!i_ctrl) begin
                    rep_d = '0;
                end else if (i_pc_debug != last_pc_q) begin
                    rep_d = REP_W'(1);
                end else if (rep_q != REP_W'(DONE_REPEAT)) begin
                    rep_d = rep_q + REP_W'(1);
                end
            end else if (cnt_active) begin
                gap_d = gap_inc;
                if (hang_enter) begin
                    max_gap_d = gap_inc;
                end
            end
        end
    end

    // Readout sources resized to CNT_W: PC and status are zero-extended or
    // truncated, max_gap saturates like the event counters.
    always_comb begin
        pc_ext = '0;
        for (int i = 0; i < PC_N; i++) begin
            pc_ext[i] = last_pc_q[i];
        end

        st_vec = '0;
        st_vec[ST_STATE_LSB +: 2] = state_q;
        st_vec[ST_DONE_BIT]       = (state_q == DONE);
        st_vec[ST_HANG_BIT]       = (state_q == HANG);
        st_vec[ST_PERR_BIT]       = proto_err_q;
        st_ext = '0;
        for (int i = 0; i < ST_N; i++) begin
            st_ext[i] = st_vec[i];
        end

        gap_ovf = 1'b0;
        for (int i = CNT_W; i < GAP_W; i++) begin
            gap_ovf = gap_ovf | max_gap_q[i];
        end
        gap_ext = '0;
        for (int i = 0; i < GAP_N; i++) begin
            gap_ext[i] = max_gap_q[i];
        end
        if (gap_ovf) begin
            gap_ext = {CNT_W{1'b1}};
        end

        case (i_rd_sel)
            SEL_CYC:    rd_mux = cyc_cnt;
            SEL_RET:    rd_mux = ret_cnt;
            SEL_CTRL:   rd_mux = ctrl_cnt;
            SEL_MIS:    rd_mux = mis_cnt;
            SEL_GAP:    rd_mux = gap_ext;
            SEL_PC:     rd_mux = pc_ext;
            SEL_STATUS: rd_mux = st_ext;
            SEL_ZERO:   rd_mux = '0;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            max_gap_q   <= '0;
            rep_q       <= '0;
            last_pc_q   <= '0;
            proto_err_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            max_gap_q   <= max_gap_d;
            rep_q       <= rep_d;
            last_pc_q   <= last_pc_d;
            proto_err_q <= proto_err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign o_rd_data   = rd_data_q;
    assign o_done      = (state_q == DONE);
    assign o_hang      = (state_q == HANG);
    assign o_proto_err = proto_err_q;

endmodule

// File: tb/tb_pipe_retire_monitor.sv
// tb/tb_pipe_retire_monitor.sv - self-checking bench for pipe_retire_monitor
module tb_pipe_retire_monitor;

    localparam int SL = 16;
    localparam int DR = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;
    localparam int S_HANG = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld, ctrl, mis, clr;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic [31:0] rd32;
    logic [3:0]  rd4;
    logic        d32, h32, p32, d4, h4, p4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_retire_monitor #(.CNT_W(32), .STALL_LIMIT(SL), .DONE_REPEAT(DR)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_insn_vld(vld), .i_ctrl(ctrl), .i_mispred(mis),
        .i_pc_debug(pc), .i_clear(clr), .i_rd_sel(sel), .o_rd_data(rd32),
        .o_done(d32), .o_hang(h32), .o_proto_err(p32)
    );

    pipe_retire_monitor #(.CNT_W(4), .STALL_LIMIT(SL), .DONE_REPEAT(DR)) dut_s (
        .i_clk(clk), .i_reset(rst_n), .i_insn_vld(vld), .i_ctrl(ctrl), .i_mispred(mis),
        .i_pc_debug(pc), .i_clear(clr), .i_rd_sel(sel), .o_rd_data(rd4),
        .o_done(d4), .o_hang(h4), .o_proto_err(p4)
    );

    // Behavioural model: unbounded event counts, saturated only when read out.
    int          m_state;
    longint      m_cyc, m_ret, m_ctrl, m_mis;
    int          m_gap, m_max, m_rep;
    logic [31:0] m_pc;
    bit          m_perr;
    logic [31:0] exp_rd32;
    logic [3:0]  exp_rd4;

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic longint model_rd(input logic [2:0] s, input int w);
        longint mask = (longint'(1) << w) - 1;
        longint st;
        st = (longint'(m_perr) << 4) | (longint'(m_state == S_HANG) << 3) |
             (longint'(m_state == S_DONE) << 2) | longint'(m_state);
        case (s)
            3'd0:    return sat(m_cyc, w);
            3'd1:    return sat(m_ret, w);
            3'd2:    return sat(m_ctrl, w);
            3'd3:    return sat(m_mis, w);
            3'd4:    return sat(longint'(m_max), w);
            3'd5:    return longint'(m_pc) & mask;
            3'd6:    return st & mask;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_cyc = 0; m_ret = 0; m_ctrl = 0; m_mis = 0;
        m_gap = 0; m_max = 0; m_rep = 0; m_pc = '0; m_perr = 0;
        exp_rd32 = '0; exp_rd4 = '0;
    endtask

    task automatic model_step(input bit v, input bit c, input bit mi,
                              input logic [31:0] p, input logic [2:0] s, input bit cl);
        int  nxt;
        bit  active;
        longint r32, r4;
        if (cl) begin
            model_reset();
            return;
        end
        r32 = model_rd(s, 32);
        r4  = model_rd(s, 4);
        active = (m_state == S_RUN) || (m_state == S_IDLE && v);
        nxt = m_state;
        if (m_state == S_IDLE && v) nxt = S_RUN;
        else if (m_state == S_RUN) begin
            if (m_rep == DR) nxt = S_DONE;
            else if (!v && (m_gap + 1 == SL)) nxt = S_HANG;
        end
        if (v && mi && !c) m_perr = 1;
        if (active) begin
            m_cyc++;
            if (v) begin
                m_ret++;
                if (c) m_ctrl++;
                if (c && mi) m_mis++;
                if (m_gap > m_max) m_max = m_gap;
                m_gap = 0;
                if (!c) m_rep = 0;
                else if (p == m_pc) m_rep = (m_rep < DR) ? m_rep + 1 : m_rep;
                else m_rep = 1;
                m_pc = p;
            end else begin
                m_gap++;
            end
        end
        if (m_state == S_RUN && nxt == S_HANG) m_max = m_gap;
        m_state  = nxt;
        exp_rd32 = 32'(r32);
        exp_rd4  = 4'(r4);
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input bit v, input bit c, input bit mi,
                         input logic [31:0] p, input logic [2:0] s, input bit cl);
        vld = v; ctrl = c; mis = mi; pc = p; sel = s; clr = cl;
        model_step(v, c, mi, p, s, cl);
        @(posedge clk);
        #1;
    endtask

    // Non-retire cycle with garbage on the qualified inputs.
    task automatic idle(input logic [2:0] s);
        drive(1'b0, 1'($urandom), 1'($urandom), $urandom, s, 1'b0);
    endtask

    task automatic do_clear();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd7, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld = 0; ctrl = 0; mis = 0; clr = 0; pc = '0; sel = 3'd1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (rd32 !== 32'd0 || rd4 !== 4'd0) begin
            n_fail++; $display("FAIL reset_rd got %0h/%0h exp 0/0", rd32, rd4);
        end
        n_tests++;
        if ({d32, h32, p32, d4, h4, p4} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 000000", {d32, h32, p32, d4, h4, p4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(3'd6);
        n_tests++;
        if (rd32 !== 32'd0 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL reset_status got %0h exp 0", rd32);
        end
    endtask

    task automatic test_basic();
        do_clear();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * i), 3'd0, 1'b0);
        idle(3'd0);
        n_tests++;
        if (rd32 !== 32'd10 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL basic_cyc got %0d exp 10", rd32);
        end
        idle(3'd1);
        n_tests++;
        if (rd32 !== 32'd10 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL basic_ret got %0d exp 10", rd32);
        end
        idle(3'd6);
        n_tests++;
        if (rd32 !== 32'd1 || d32 !== 1'b0 || h32 !== 1'b0) begin
            n_fail++; $display("FAIL basic_status got %0h done %b hang %b exp 1 0 0", rd32, d32, h32);
        end
    endtask

    task automatic test_counts();
        do_clear();
        for (int i = 0; i < 20; i++)
            drive(1'b1, (i % 3 == 2), (i == 5 || i == 11 || i == 19),
                  32'h200 + 32'(4 * i), 3'd0, 1'b0);
        idle(3'd2);
        n_tests++;
        if (rd32 !== 32'd6 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL counts_ctrl got %0d exp 6", rd32);
        end
        idle(3'd3);
        n_tests++;
        if (rd32 !== 32'd2 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL counts_mis got %0d exp 2", rd32);
        end
        idle(3'd6);
        n_tests++;
        if (p32 !== 1'b1 || rd32 !== 32'd17) begin
            n_fail++; $display("FAIL counts_proto got perr %b status %0h exp 1 11", p32, rd32);
        end
    endtask

    task automatic test_gap();
        int hang_at;
        do_clear();
        drive(1'b1, 1'b0, 1'b0, 32'h300, 3'd4, 1'b0);
        repeat (7) idle(3'd4);
        drive(1'b1, 1'b0, 1'b0, 32'h304, 3'd4, 1'b0);
        repeat (3) idle(3'd4);
        drive(1'b1, 1'b0, 1'b0, 32'h308, 3'd4, 1'b0);
        hang_at = 0;
        for (int k = 1; k <= 40; k++) begin
            idle(3'd4);
            if (k == 1) begin
                n_tests++;
                if (rd32 !== 32'd7 || rd32 !== exp_rd32) begin
                    n_fail++; $display("FAIL gap_max got %0d exp 7", rd32);
                end
            end
            if (h32 === 1'b1) begin
                hang_at = k;
                break;
            end
        end
        n_tests++;
        if (hang_at != SL) begin
            n_fail++; $display("FAIL gap_hang_latency got %0d exp %0d", hang_at, SL);
        end
        idle(3'd6);
        n_tests++;
        if (rd32 !== 32'd11) begin
            n_fail++; $display("FAIL gap_hang_status got %0h exp b", rd32);
        end
        idle(3'd4);
        n_tests++;
        if (rd32 !== 32'd16 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL gap_hang_max got %0d exp 16", rd32);
        end
        repeat (3) drive(1'b1, 1'b1, 1'b1, 32'h30c, 3'd1, 1'b0);
        idle(3'd1);
        n_tests++;
        if (rd32 !== 32'd3 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL gap_freeze_ret got %0d exp 3", rd32);
        end
        idle(3'd0);
        n_tests++;
        if (rd32 !== 32'd29 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL gap_freeze_cyc got %0d exp 29", rd32);
        end
    endtask

    task automatic test_done();
        do_clear();
        repeat (4) drive(1'b1, 1'b1, 1'b0, 32'h40, 3'd1, 1'b0);
        n_tests++;
        if (d32 !== 1'b0) begin
            n_fail++; $display("FAIL done_early got %b exp 0", d32);
        end
        idle(3'd1);
        n_tests++;
        if (d32 !== 1'b1 || rd32 !== 32'd4) begin
            n_fail++; $display("FAIL done_set got done %b ret %0d exp 1 4", d32, rd32);
        end
        idle(3'd6);
        n_tests++;
        if (rd32 !== 32'd6 || h32 !== 1'b0) begin
            n_fail++; $display("FAIL done_status got %0h hang %b exp 6 0", rd32, h32);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h40, 3'd1, 1'b0);
        idle(3'd1);
        n_tests++;
        if (rd32 !== 32'd4 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL done_freeze_ret got %0d exp 4", rd32);
        end
    endtask

    task automatic test_no_done();
        do_clear();
        repeat (3) drive(1'b1, 1'b1, 1'b0, 32'h40, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h44, 3'd0, 1'b0);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 32'h40, 3'd0, 1'b0);
        repeat (2) idle(3'd6);
        n_tests++;
        if (d32 !== 1'b0 || rd32 !== 32'd1) begin
            n_fail++; $display("FAIL nodone got done %b status %0h exp 0 1", d32, rd32);
        end
    endtask

    task automatic test_saturate();
        do_clear();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 32'h500 + 32'(4 * i), 3'd1, 1'b0);
        idle(3'd1);
        n_tests++;
        if (rd4 !== 4'd15 || rd32 !== 32'd20) begin
            n_fail++; $display("FAIL sat_ret got %0d/%0d exp 15/20", rd4, rd32);
        end
        drive(1'b1, 1'b1, 1'b1, 32'h600, 3'd1, 1'b1);
        n_tests++;
        if (rd4 !== 4'd0 || rd32 !== 32'd0) begin
            n_fail++; $display("FAIL clear_rd got %0d/%0d exp 0/0", rd4, rd32);
        end
        idle(3'd6);
        n_tests++;
        if (rd32 !== 32'd0 || p32 !== 1'b0) begin
            n_fail++; $display("FAIL clear_state got %0h perr %b exp 0 0", rd32, p32);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h604, 3'd1, 1'b0);
        idle(3'd1);
        n_tests++;
        if (rd32 !== 32'd1 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL clear_reenter got %0d exp 1", rd32);
        end
        repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h608, 3'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (rd32 !== 32'd0 || rd4 !== 4'd0) begin
            n_fail++; $display("FAIL async_reset_rd got %0h/%0h exp 0/0", rd32, rd4);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h700, 3'd1, 1'b0);
        idle(3'd1);
        n_tests++;
        if (rd32 !== 32'd1 || rd32 !== exp_rd32) begin
            n_fail++; $display("FAIL reset_reenter got %0d exp 1", rd32);
        end
    endtask

    task automatic test_random();
        bit          v, c, mi, cl;
        logic [31:0] p;
        logic [2:0]  s;
        int          phase;
        do_clear();
        for (int i = 0; i < 720; i++) begin
            phase = (i / 60) % 3;
            case (phase)
                0: v = ($urandom % 10) < 7;
                1: v = ($urandom % 20) == 0;
                default: v = ($urandom % 10) < 9;
            endcase
            if (phase == 2) begin
                c = ($urandom % 5) != 0;
                p = (($urandom % 4) == 0) ? 32'h44 : 32'h40;
            end else begin
                c = 1'($urandom);
                p = $urandom & 32'h0000_00fc;
            end
            mi = ($urandom % 4) == 0;
            s  = 3'($urandom);
            cl = ($urandom % 50) == 0;
            drive(v, c, mi, p, s, cl);
            n_tests++;
            if (rd32 !== exp_rd32) begin
                n_fail++; $display("FAIL rand_rd32 cyc %0d sel %0d got %0h exp %0h", i, s, rd32, exp_rd32);
            end
            n_tests++;
            if (rd4 !== exp_rd4) begin
                n_fail++; $display("FAIL rand_rd4 cyc %0d sel %0d got %0h exp %0h", i, s, rd4, exp_rd4);
            end
            n_tests++;
            if ({d32, h32, p32, d4, h4, p4} !==
                {2{m_state == S_DONE, m_state == S_HANG, m_perr}}) begin
                n_fail++; $display("FAIL rand_flags cyc %0d got %b exp state %0d perr %b",
                                   i, {d32, h32, p32, d4, h4, p4}, m_state, m_perr);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_counts();
        test_gap();
        test_done();
        test_no_done();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
